// File: rtl/mrsc_pkg.sv
// Shared MRSC constants and the 16->32 bit codeword encoder function.
// Bit 0 of data/codeword is the MSB, matching the decoder's [0:N] numbering.
package mrsc_pkg;

    localparam int unsigned MRSC_DATA_W = 16;
    localparam int unsigned MRSC_CW_W   = 32;
    localparam int unsigned MRSC_ROWS   = 4;
    localparam int unsigned MRSC_ROW_W  = 8;

    localparam int unsigned ROW_P0 = 6;
    localparam int unsigned ROW_P1 = 7;
    localparam int unsigned XCHK0  = 4;
    localparam int unsigned XCHK1  = 5;

    // One row with its data nibble and row checks; column/diagonal slots left zero.
    function automatic logic [0:MRSC_ROW_W-1] mrsc_row(input logic [0:3] nib);
        logic [0:MRSC_ROW_W-1] row;
        row          = '0;
        row[0:3]     = nib;
        row[ROW_P0]  = nib[0] ^ nib[2];
        row[ROW_P1]  = nib[1] ^ nib[3];
        return row;
    endfunction

    function automatic logic [MRSC_CW_W-1:0] mrsc_encode(input logic [MRSC_DATA_W-1:0] data);
        logic [0:MRSC_DATA_W-1] d;
        logic [0:MRSC_ROW_W-1]  s0, s1, s2, s3;
        logic [0:3]             x;
        d  = data;
        s0 = mrsc_row(d[0:3]);
        s1 = mrsc_row(d[4:7]);
        s2 = mrsc_row(d[8:11]);
        s3 = mrsc_row(d[12:15]);
        x  = s0[0:3] ^ s1[0:3] ^ s2[0:3] ^ s3[0:3];
        s2[XCHK0] = x[0];
        s3[XCHK0] = x[1];
        s2[XCHK1] = x[2];
        s3[XCHK1] = x[3];
        s0[XCHK0] = s0[0] ^ s1[1] ^ s2[0] ^ s3[1];
        s1[XCHK0] = s0[1] ^ s1[0] ^ s2[1] ^ s3[0];
        s0[XCHK1] = s0[2] ^ s1[3] ^ s2[2] ^ s3[3];
        s1[XCHK1] = s0[3] ^ s1[2] ^ s2[3] ^ s3[2];
        return {s0, s1, s2, s3};
    endfunction

endpackage

// File: rtl/mrsc_enc_core.sv
// Combinational MRSC encoder: 16-bit data word to 32-bit codeword.
module mrsc_enc_core
    import mrsc_pkg::*;
(
    input  logic [MRSC_DATA_W-1:0] data,
    output logic [MRSC_CW_W-1:0]   codeword
);

    always_comb begin
        codeword = mrsc_encode(data);
    end

endmodule

// File: rtl/mrsc_encoder.sv
// MRSC encoder front end: encodes accepted words, applies the injection mask and
// queues codewords in a small valid/ready FIFO with a saturating accept counter.
module mrsc_encoder
    import mrsc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MRSC_DATA_W-1:0]   data_in,
    input  logic [MRSC_CW_W-1:0]     inj_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MRSC_CW_W-1:0]     data_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         words_enc,
    input  logic                     clear_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       level_q, level_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MRSC_CW_W-1:0] mem_q [DEPTH];
    logic [MRSC_CW_W-1:0] codeword;
    logic                 push, pop;

    mrsc_enc_core u_enc_core (
        .data     (data_in),
        .codeword (codeword)
    );

    // Handshake derives from registered level only, so in_ready never sees out_ready.
    always_comb begin
        in_ready   = (level_q < FULL_LVL);
        out_valid  = (level_q != '0);
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        data_out   = out_valid ? mem_q[rd_ptr_q] : '0;
        fifo_level = level_q;
        words_enc  = cnt_q;
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (push && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= codeword ^ inj_mask;
        end
    end

endmodule

// File: tb/tb_mrsc_encoder.sv
// Self-checking bench for mrsc_encoder: directed vectors, backpressure, counter,
// async reset and a randomized run against a queue-based reference model.
module tb_mrsc_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   data_in;
    logic [31:0]   inj_mask;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   data_out;
    logic [LW-1:0] fifo_level;
    logic [CNT_W-1:0] words_enc;
    logic          clear_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mrsc_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .inj_mask   (inj_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .fifo_level (fifo_level),
        .words_enc  (words_enc),
        .clear_cnt  (clear_cnt)
    );

    always #5 clk = ~clk;

    // Grid bit (r,b) lives at codeword position 8r+b counted from the MSB.
    function automatic int gb(input logic [31:0] g, input int r, input int b);
        return int'((g >> (31 - 8 * r - b)) & 32'd1);
    endfunction

    function automatic logic [31:0] gset(input logic [31:0] g, input int r, input int b,
                                         input int v);
        return (v % 2 != 0) ? (g | (32'd1 << (31 - 8 * r - b))) : g;
    endfunction

    function automatic logic [31:0] model_enc(input logic [15:0] d);
        logic [31:0] g = '0;
        int colsum;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g = gset(g, r, c, int'((d >> (15 - 4 * r - c)) & 16'd1));
        for (int r = 0; r < 4; r++) begin
            g = gset(g, r, 6, gb(g, r, 0) + gb(g, r, 2));
            g = gset(g, r, 7, gb(g, r, 1) + gb(g, r, 3));
        end
        for (int c = 0; c < 4; c++) begin
            colsum = gb(g, 0, c) + gb(g, 1, c) + gb(g, 2, c) + gb(g, 3, c);
            g = gset(g, 2 + (c % 2), 4 + (c / 2), colsum);
        end
        g = gset(g, 0, 4, gb(g, 0, 0) + gb(g, 1, 1) + gb(g, 2, 0) + gb(g, 3, 1));
        g = gset(g, 1, 4, gb(g, 0, 1) + gb(g, 1, 0) + gb(g, 2, 1) + gb(g, 3, 0));
        g = gset(g, 0, 5, gb(g, 0, 2) + gb(g, 1, 3) + gb(g, 2, 2) + gb(g, 3, 3));
        g = gset(g, 1, 5, gb(g, 0, 3) + gb(g, 1, 2) + gb(g, 2, 3) + gb(g, 3, 2));
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; inj_mask = '0;
        out_ready = 1'b0; clear_cnt = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (data_out !== 32'h0) $display("FAIL reset_data_out got %h want 0", data_out);
        else n_pass++;
        n_checks++;
        if (fifo_level !== '0 || words_enc !== '0)
            $display("FAIL reset_level_cnt got %0d/%0d want 0/0", fifo_level, words_enc);
        else n_pass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [15:0] vd [5];
        logic [31:0] vm [5];
        logic [31:0] ve [5];
        vd[0] = 16'hFFFF; vm[0] = 32'h0;        ve[0] = 32'hF0F0F0F0;
        vd[1] = 16'h8000; vm[1] = 32'h0;        ve[1] = 32'h8A000800;
        vd[2] = 16'h1000; vm[2] = 32'h0;        ve[2] = 32'h11040004;
        vd[3] = 16'h0000; vm[3] = 32'h0;        ve[3] = 32'h00000000;
        vd[4] = 16'h8000; vm[4] = 32'h80000000; ve[4] = 32'h0A000800;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; data_in = vd[i]; inj_mask = vm[i];
            step();
            in_valid = 1'b0; inj_mask = '0;
            n_checks++;
            if (out_valid !== 1'b1 || data_out !== ve[i])
                $display("FAIL vector%0d got v=%b %h want v=1 %h", i, out_valid, data_out, ve[i]);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (words_enc !== 16'd1) $display("FAIL vector_cnt got %0d want 1", words_enc);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
        do_reset();
        out_ready = 1'b0; inj_mask = '0;
        in_valid = 1'b1; data_in = w[0]; step();
        data_in = w[1]; step();
        data_in = w[2]; step();
        n_checks++;
        if (fifo_level !== LW'(2) || in_ready !== 1'b0 || data_out !== model_enc(w[0]))
            $display("FAIL b2b_full got lvl=%0d rdy=%b %h want 2 0 %h",
                     fifo_level, in_ready, data_out, model_enc(w[0]));
        else n_pass++;
        out_ready = 1'b1;
        n_checks++;
        if (data_out !== model_enc(w[0])) $display("FAIL b2b_a got %h want %h", data_out, model_enc(w[0]));
        else n_pass++;
        step();
        n_checks++;
        if (data_out !== model_enc(w[1]) || in_ready !== 1'b1)
            $display("FAIL b2b_b got %h rdy=%b want %h 1", data_out, in_ready, model_enc(w[1]));
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (data_out !== model_enc(w[2]) || fifo_level !== LW'(1))
            $display("FAIL b2b_c got %h lvl=%0d want %h 1", data_out, fifo_level, model_enc(w[2]));
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || words_enc !== 16'd3)
            $display("FAIL b2b_end got v=%b cnt=%0d want 0 3", out_valid, words_enc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        int  model_cnt = 0;
        bit  push = 1'b0, pop;
        logic [31:0] exp_out;
        do_reset();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            // A refused offer is held unchanged; otherwise draw a fresh one.
            if (!(in_valid && !push)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                data_in  = 16'($urandom);
                inj_mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            exp_out = (q.size() != 0) ? q[0] : 32'h0;
            n_checks++;
            if (in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() != 0) ||
                fifo_level !== LW'(q.size()) || words_enc !== CNT_W'(model_cnt))
                $display("FAIL rand_status cyc%0d got rdy=%b v=%b lvl=%0d cnt=%0d want lvl=%0d cnt=%0d",
                         cyc, in_ready, out_valid, fifo_level, words_enc, q.size(), model_cnt);
            else n_pass++;
            n_checks++;
            if (data_out !== exp_out)
                $display("FAIL rand_data cyc%0d got %h want %h", cyc, data_out, exp_out);
            else n_pass++;
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() != 0);
            step();
            if (pop)  void'(q.pop_front());
            if (push) begin
                q.push_back(model_enc(data_in) ^ inj_mask);
                if (model_cnt < 65535) model_cnt++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturate();
        clear_cnt = 1'b1; in_valid = 1'b0; step();
        clear_cnt = 1'b0; out_ready = 1'b1; inj_mask = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            data_in = 16'(i);
            step();
        end
        n_checks++;
        if (words_enc !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", words_enc);
        else n_pass++;
        step();
        n_checks++;
        if (words_enc !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", words_enc);
        else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_clear();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; data_in = 16'($urandom);
        step(); step();
        n_checks++;
        if (words_enc !== 16'd2) $display("FAIL clear_pre got %0d want 2", words_enc);
        else n_pass++;
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        n_checks++;
        if (words_enc !== 16'd0) $display("FAIL clear_coincide got %0d want 0", words_enc);
        else n_pass++;
        step();
        n_checks++;
        if (words_enc !== 16'd1) $display("FAIL clear_after got %0d want 1", words_enc);
        else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; data_in = 16'hFFFF; inj_mask = '0;
        step(); step();
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== LW'(2) || data_out !== 32'hF0F0F0F0)
            $display("FAIL arst_pre got lvl=%0d %h want 2 f0f0f0f0", fifo_level, data_out);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== '0 || data_out !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL arst_flush got v=%b lvl=%0d %h rdy=%b want 0 0 0 1",
                     out_valid, fifo_level, data_out, in_ready);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL arst_post got v=%b want 0", out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_saturate();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
